pulse_seq_ctrl: RTL

Synthesizable, clocked pulse-train controller: on a start handshake it latches delay, width, period and count configuration, then drives a digital pulse output with cycle-exact timing until the burst completes or is stopped. It replaces free-running behavioural pulse stimulus wherever pulses must be sequenced from a clock domain, such as bench sequencers or calibration triggers. It reports busy/done/error status back to the requester.

---
 rtl/pulse_seq_pkg.sv | 14 +
 rtl/pulse_seq_if.sv | 33 +++
 rtl/pulse_seq_timer.sv | 29 ++
 rtl/pulse_seq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse-train sequencer.
// No ports: exports the FSM state enum and the default field width.
package pulse_seq_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pulse_seq_if.sv
// Request/status bundle between a requester and the pulse sequencer.
// master: drives start/stop/cfg_*, reads out/outb/busy/done/err/pulse_cnt.
// slave:  the sequencer side of the same signals.
interface pulse_seq_if
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_td;
  logic [CNT_W-1:0] cfg_tw;
  logic [CNT_W-1:0] cfg_tp;
  logic [CNT_W-1:0] cfg_n;
  logic             out;
  logic             outb;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, stop, cfg_td, cfg_tw, cfg_tp, cfg_n,
    input  out, outb, busy, done, err, pulse_cnt
  );

  modport slave (
    input  start, stop, cfg_td, cfg_tw, cfg_tp, cfg_n,
    output out, outb, busy, done, err, pulse_cnt
  );

endinterface

// File: rtl/pulse_seq_timer.sv
// Loadable down-counter used as the phase timer of the sequencer.
// Ports: clk, rst (sync, high), load, load_val in; zero out (count==0).
module pulse_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-train controller: delay, then n pulses of width tw every tp cycles.
// Ports: clk, rst (sync, high); bus (pulse_seq_if.slave) for cfg/status.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter logic B0    = 1'b0,
  parameter int   CNT_W = DEFAULT_CNT_W
) (
  input logic       clk,
  input logic       rst,
  pulse_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, next;

  logic [CNT_W-1:0] tw_q, tp_q, n_q, cnt_q;
  logic             out_q, busy_q, done_q, err_q;

  logic             tload, tzero;
  logic [CNT_W-1:0] tval;
  logic             accept, rej, fin, enter_high;
  logic             cfg_ok, last;
  logic [CNT_W-1:0] tw_m1, lo_m1;

  assign cfg_ok = (bus.cfg_tw != '0) && (bus.cfg_tp > bus.cfg_tw);
  assign last   = (n_q != '0) && (cnt_q == n_q);
  assign tw_m1  = tw_q - ONE;
  assign lo_m1  = tp_q - tw_q - ONE;

  pulse_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Timer holds (cycles left - 1). DELAY is loaded with td itself, so
  // it spans td+1 cycles and absorbs the one-cycle accept latency;
  // the delay value goes straight into the timer and is never stored.
  always_comb begin
    next       = state;
    tload      = 1'b0;
    tval       = '0;
    accept     = 1'b0;
    rej        = 1'b0;
    fin        = 1'b0;
    enter_high = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (cfg_ok) begin
            accept = 1'b1;
            next   = DELAY;
            tload  = 1'b1;
            tval   = bus.cfg_td;
          end else begin
            rej = 1'b1;
          end
        end
      end
      DELAY: begin
        if (bus.stop) begin
          next = IDLE;
        end else if (tzero) begin
          next       = HIGH;
          tload      = 1'b1;
          tval       = tw_m1;
          enter_high = 1'b1;
        end
      end
      HIGH: begin
        if (bus.stop) begin
          next = IDLE;
        end else if (tzero) begin
          if (last) begin
            next = IDLE;
            fin  = 1'b1;
          end else begin
            next  = LOW;
            tload = 1'b1;
            tval  = lo_m1;
          end
        end
      end
      LOW: begin
        if (bus.stop) begin
          next = IDLE;
        end else if (tzero) begin
          next       = HIGH;
          tload      = 1'b1;
          tval       = tw_m1;
          enter_high = 1'b1;
        end
      end
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change exactly
  // at the edge the FSM moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= B0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      tw_q   <= '0;
      tp_q   <= '0;
      n_q    <= '0;
    end else begin
      out_q  <= (next == HIGH) ? ~B0 : B0;
      busy_q <= (next != IDLE);
      done_q <= fin;
      err_q  <= rej;
      if (accept) begin
        tw_q  <= bus.cfg_tw;
        tp_q  <= bus.cfg_tp;
        n_q   <= bus.cfg_n;
        cnt_q <= '0;
      end else if (enter_high && !(&cnt_q)) begin
        cnt_q <= cnt_q + ONE;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.outb      = ~out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pulse_cnt = cnt_q;

endmodule
